facto_master: RTL

FACTO_MASTER -- requirements
Module: facto_master

---
 rtl/facto_pkg.sv | 25 ++
 rtl/facto_bus_if.sv | 90 +++++++++
 rtl/facto_master.sv | 123 ++++++++++++
 3 files changed

// File: rtl/facto_pkg.sv
// Shared definitions for the factorial-core bus master: register offsets
// inside the core window and the sequencer state enumeration.
package facto_pkg;

   localparam logic [15:0] OFS_OPSTART  = 16'h0000;
   localparam logic [15:0] OFS_OPCLEAR  = 16'h0008;
   localparam logic [15:0] OFS_INTREN   = 16'h0018;
   localparam logic [15:0] OFS_OPERAND  = 16'h0020;
   localparam logic [15:0] OFS_RESULT_H = 16'h0028;
   localparam logic [15:0] OFS_RESULT_L = 16'h0030;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_OPND,
      S_WR_IEN,
      S_WR_START,
      S_WAIT_IRQ,
      S_RD_L,
      S_RD_H,
      S_WR_CLR1,
      S_WR_CLR0,
      S_DONE
   } factoState_t;

endpackage

// File: rtl/facto_bus_if.sv
// Bus encoder: turns the sequencer state (plus the operand to write) into
// registered m_sel/m_wr/m_addr/m_dout. The top feeds it the next state so
// the registered bus lines line up with the state they belong to.
module facto_bus_if
   import facto_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h7000
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  factoState_t i_state,
   input  logic [63:0] i_operand,
   output logic        o_sel,
   output logic        o_wr,
   output logic [15:0] o_addr,
   output logic [63:0] o_dout
);

   logic        w_sel;
   logic        w_wr;
   logic [15:0] w_addr;
   logic [63:0] w_dout;

   // Decode which register access (if any) the given state performs.
   always_comb begin
      w_sel  = 1'b0;
      w_wr   = 1'b0;
      w_addr = 16'h0000;
      w_dout = 64'd0;
      case (i_state)
         S_WR_OPND: begin
            w_sel  = 1'b1;
            w_wr   = 1'b1;
            w_addr = BASE_ADDR + OFS_OPERAND;
            w_dout = i_operand;
         end
         S_WR_IEN: begin
            w_sel  = 1'b1;
            w_wr   = 1'b1;
            w_addr = BASE_ADDR + OFS_INTREN;
            w_dout = 64'd1;
         end
         S_WR_START: begin
            w_sel  = 1'b1;
            w_wr   = 1'b1;
            w_addr = BASE_ADDR + OFS_OPSTART;
            w_dout = 64'd1;
         end
         S_RD_L: begin
            w_sel  = 1'b1;
            w_addr = BASE_ADDR + OFS_RESULT_L;
         end
         S_RD_H: begin
            w_sel  = 1'b1;
            w_addr = BASE_ADDR + OFS_RESULT_H;
         end
         S_WR_CLR1: begin
            w_sel  = 1'b1;
            w_wr   = 1'b1;
            w_addr = BASE_ADDR + OFS_OPCLEAR;
            w_dout = 64'd1;
         end
         S_WR_CLR0: begin
            w_sel  = 1'b1;
            w_wr   = 1'b1;
            w_addr = BASE_ADDR + OFS_OPCLEAR;
         end
         default: begin
            w_sel  = 1'b0;
         end
      endcase
   end

   // Register the bus lines so the slave sees glitch-free signals.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_sel  <= 1'b0;
         o_wr   <= 1'b0;
         o_addr <= 16'h0000;
         o_dout <= 64'd0;
      end else begin
         o_sel  <= w_sel;
         o_wr   <= w_wr;
         o_addr <= w_addr;
         o_dout <= w_dout;
      end
   end

endmodule

// File: rtl/facto_master.sv
// Host-side sequencer for the factorial core: writes operand, enables the
// interrupt, starts the core, waits for the interrupt (with timeout), reads
// the 128-bit result, clears the core and reports done/error to the host.
module facto_master
   import facto_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h7000,
   parameter int          TIMEOUT   = 65535
)
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [63:0]  operand,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic [127:0] result,
   output logic         m_sel,
   output logic         m_wr,
   output logic [15:0]  m_addr,
   output logic [63:0]  m_dout,
   input  logic [63:0]  m_din,
   input  logic         interrupt
);

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   factoState_t  r_state;
   factoState_t  w_nextState;
   logic         r_rdPhase;
   logic [15:0]  r_waitCnt;
   logic [63:0]  r_operand;
   logic         r_abort;
   logic         r_busy;
   logic         r_done;
   logic         r_error;
   logic [127:0] r_result;
   logic         w_timeout;
   logic [63:0]  w_busOperand;

   assign w_timeout    = (r_state == S_WAIT_IRQ) && !interrupt && (r_waitCnt == WAIT_LAST);
   assign w_busOperand = (r_state == S_IDLE) ? operand : r_operand;

   // Next-state selection; reads stay in their state for two cycles.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:     if (start) w_nextState = S_WR_OPND;
         S_WR_OPND:  w_nextState = S_WR_IEN;
         S_WR_IEN:   w_nextState = S_WR_START;
         S_WR_START: w_nextState = S_WAIT_IRQ;
         S_WAIT_IRQ: begin
            if (interrupt)      w_nextState = S_RD_L;
            else if (w_timeout) w_nextState = S_WR_CLR1;
         end
         S_RD_L:     if (r_rdPhase) w_nextState = S_RD_H;
         S_RD_H:     if (r_rdPhase) w_nextState = S_WR_CLR1;
         S_WR_CLR1:  w_nextState = S_WR_CLR0;
         S_WR_CLR0:  w_nextState = S_DONE;
         S_DONE:     w_nextState = S_IDLE;
         default:    w_nextState = S_IDLE;
      endcase
   end

   // Sequencer state, wait counter, result capture and registered host outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_rdPhase <= 1'b0;
         r_waitCnt <= 16'd0;
         r_operand <= 64'd0;
         r_abort   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_result  <= 128'd0;
      end else begin
         r_state   <= w_nextState;
         r_busy    <= (w_nextState != S_IDLE) && (w_nextState != S_DONE);
         r_done    <= (w_nextState == S_DONE);
         r_waitCnt <= ((r_state == S_WAIT_IRQ) && (w_nextState == S_WAIT_IRQ)) ?
                      (r_waitCnt + 16'd1) : 16'd0;
         r_rdPhase <= ((r_state == S_RD_L) || (r_state == S_RD_H)) ? ~r_rdPhase : 1'b0;
         if ((r_state == S_IDLE) && start) begin
            r_operand <= operand;
            r_abort   <= 1'b0;
            r_error   <= 1'b0;
         end
         if (w_timeout) begin
            r_abort <= 1'b1;
         end
         if ((r_state == S_RD_L) && r_rdPhase) begin
            r_result[63:0] <= m_din;
         end
         if ((r_state == S_RD_H) && r_rdPhase) begin
            r_result[127:64] <= m_din;
         end
         if (w_nextState == S_DONE) begin
            r_error <= r_abort;
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign error  = r_error;
   assign result = r_result;

   facto_bus_if #(
      .BASE_ADDR (BASE_ADDR)
   ) u_busIf (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_state   (w_nextState),
      .i_operand (w_busOperand),
      .o_sel     (m_sel),
      .o_wr      (m_wr),
      .o_addr    (m_addr),
      .o_dout    (m_dout)
   );

endmodule
